// File: rtl/uart_msg_spam_pkg.sv
// Shared types for the repeating UART message transmitter.
// Holds the FSM encoding and the clocks-per-bit helper.
package uart_msg_spam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam int CntW = 8;

    // A tick fires DivIncr/2^DivWidth times per clock, so one bit lasts
    // 2^DivWidth/DivIncr clocks on average.
    function automatic int clk_per_bit(int div_width, int div_incr);
        return (1 << div_width) / div_incr;
    endfunction

endpackage

// File: rtl/uart_msg_spam_if.sv
// Message buffer write port bundle.
// The master side fills the buffer, the transmitter consumes it.
interface uart_msg_spam_if #(
    parameter int DataBits = 8,
    parameter int Depth    = 16
) ();

    logic                     wr_en;
    logic [$clog2(Depth)-1:0] wr_addr;
    logic [DataBits-1:0]      wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/uart_frac_tick.sv
// Fractional bit-rate divider: free-running accumulator,
// tick is the carry out of each addition.
module uart_frac_tick #(
    parameter int DivWidth = 15,
    parameter int DivIncr  = 314
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [DivWidth-1:0] acc;
    logic [DivWidth:0]   sum;

    assign sum  = {1'b0, acc} + (DivWidth+1)'(DivIncr);
    assign tick = sum[DivWidth];

    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else       acc <= sum[DivWidth-1:0];
    end

endmodule

// File: rtl/uart_msg_spam.sv
// Repeating UART message transmitter: sends buffer[0..len-1]
// as framed characters, then an optional idle gap, forever.
module uart_msg_spam
    import uart_msg_spam_pkg::*;
#(
    parameter int DataBits = 8,
    parameter int Depth    = 16,
    parameter int DivWidth = 15,
    parameter int DivIncr  = 314,
    parameter int StopBits = 1,
    parameter int GapBits  = 0,
    parameter int InvertTx = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [$clog2(Depth):0]   msg_len,
    uart_msg_spam_if.slave           wr,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(Depth)-1:0] char_idx,
    output logic                     msg_done
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;
    localparam logic [CntW-1:0] DataLast = CntW'(DataBits - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(StopBits - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapBits > 0 ? GapBits - 1 : 0);
    localparam logic [LW-1:0]   MaxLen   = LW'(Depth);

    logic [DataBits-1:0] mem [Depth];

    state_t              state, state_n;
    logic [CntW-1:0]     cnt, cnt_n;
    logic [AW-1:0]       idx, idx_n;
    logic [LW-1:0]       len, len_n;
    logic [DataBits-1:0] sh;
    logic                done, done_n;
    logic                ld, shift, eom, go, tick, line;

    uart_frac_tick #(
        .DivWidth(DivWidth),
        .DivIncr (DivIncr)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign go = enable && (msg_len != '0);

    // Buffer is never cleared by reset; it only changes on writes.
    always_ff @(posedge clk) begin
        if (wr.wr_en) mem[wr.wr_addr] <= wr.wr_data;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = len;
        ld      = 1'b0;
        shift   = 1'b0;
        eom     = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_START: if (tick) begin
                state_n = S_DATA;
                cnt_n   = '0;
            end
            S_DATA: if (tick) begin
                shift = 1'b1;
                if (cnt == DataLast) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STOP: if (tick) begin
                if (cnt != StopLast) begin
                    cnt_n = cnt + 1'b1;
                end else if ((LW'(idx) + LW'(1)) < len) begin
                    idx_n   = idx + 1'b1;
                    state_n = S_START;
                    ld      = 1'b1;
                end else if (GapBits > 0) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else begin
                    eom = 1'b1;
                end
            end
            S_GAP: if (tick) begin
                if (cnt == GapLast) eom = 1'b1;
                else                cnt_n = cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // Leaving IDLE is not tick-gated, so the first start bit may be short.
        if ((state == S_IDLE || eom) && go) begin
            state_n = S_START;
            idx_n   = '0;
            len_n   = (msg_len > MaxLen) ? MaxLen : msg_len;
            ld      = 1'b1;
        end else if (eom) begin
            state_n = S_IDLE;
            idx_n   = '0;
        end
        done_n = eom;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            len   <= '0;
            done  <= 1'b0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            len   <= len_n;
            done  <= done_n;
            if (ld)         sh <= mem[idx_n];
            else if (shift) sh <= sh >> 1;
        end
    end

    always_comb begin
        line = 1'b1;
        if (state == S_START)     line = 1'b0;
        else if (state == S_DATA) line = sh[0];
    end

    assign tx       = (InvertTx != 0) ? ~line : line;
    assign busy     = (state != S_IDLE);
    assign char_idx = idx;
    assign msg_done = done;

endmodule

// File: tb/tb_uart_msg_spam.sv
// Self-checking bench for uart_msg_spam: directed vector tables,
// hand-written corner sequences and a randomized run against a line model.
module tb_uart_msg_spam;
    import uart_msg_spam_pkg::*;

    localparam int DB  = 8;
    localparam int DEP = 4;
    localparam int AW  = 2;
    localparam int W   = 4;
    localparam int INC = 4;
    localparam int SB  = 1;
    localparam int G0  = 0;
    localparam int G1  = 3;
    localparam int P   = clk_per_bit(W, INC);

    typedef struct {
        int          grp;
        int          inst;
        int          cyc;
        logic        tx;
        logic        busy;
        logic        done;
        logic [AW-1:0] idx;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW:0]   msg_len = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DB-1:0] wr_data = '0;
    logic [1:0]    tx, busy, done;
    logic [AW-1:0] cidx0, cidx1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_on = 1'b0;
    vec_t tbl[$];

    // line model state
    logic [DB-1:0] mem_m [DEP];
    int            acc = 0;
    bit            act [2];
    bit            in_gap [2];
    bit            mdone [2];
    int            idx [2];
    int            mlen [2];
    int            pos [2];
    int            seglen [2];
    logic [DB-1:0] chr [2];

    uart_msg_spam_if #(.DataBits(DB), .Depth(DEP)) w0 ();
    uart_msg_spam_if #(.DataBits(DB), .Depth(DEP)) w1 ();

    assign w0.wr_en   = wr_en;
    assign w0.wr_addr = wr_addr;
    assign w0.wr_data = wr_data;
    assign w1.wr_en   = wr_en;
    assign w1.wr_addr = wr_addr;
    assign w1.wr_data = wr_data;

    uart_msg_spam #(
        .DataBits(DB), .Depth(DEP), .DivWidth(W), .DivIncr(INC),
        .StopBits(SB), .GapBits(G0), .InvertTx(0)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable), .msg_len(msg_len),
        .wr(w0), .tx(tx[0]), .busy(busy[0]), .char_idx(cidx0),
        .msg_done(done[0])
    );

    uart_msg_spam #(
        .DataBits(DB), .Depth(DEP), .DivWidth(W), .DivIncr(INC),
        .StopBits(SB), .GapBits(G1), .InvertTx(0)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .msg_len(msg_len),
        .wr(w1), .tx(tx[1]), .busy(busy[1]), .char_idx(cidx1),
        .msg_done(done[1])
    );

    always #5 clk = ~clk;

    function automatic logic fbit(logic [7:0] d, int b);
        if (b == 0)  return 1'b0;
        if (b <= DB) return d[b-1];
        return 1'b1;
    endfunction

    function automatic logic exp_tx(int k);
        if (!act[k] || in_gap[k]) return 1'b1;
        return fbit(chr[k], pos[k]);
    endfunction

    function automatic logic [15:0] pack(int k);
        return {11'b0, tx[k], busy[k], done[k], (k == 0) ? cidx0 : cidx1};
    endfunction

    function automatic vec_t mk(int g, int k, int c, logic t, logic b,
                                logic d, int i);
        vec_t v;
        v.grp = g; v.inst = k; v.cyc = c;
        v.tx = t; v.busy = b; v.done = d; v.idx = AW'(i);
        return v;
    endfunction

    task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp,
                     $time);
        end
    endtask

    task automatic load_char(int k);
        chr[k]    = mem_m[idx[k]];
        pos[k]    = 0;
        seglen[k] = 1 + DB + SB;
        in_gap[k] = 1'b0;
    endtask

    task automatic start_msg(int k);
        mlen[k] = (int'(msg_len) > DEP) ? DEP : int'(msg_len);
        idx[k]  = 0;
        act[k]  = 1'b1;
        load_char(k);
    endtask

    // Reference behaviour: bit sequences per character plus gap, advanced
    // one bit per divider carry.
    task automatic model_step();
        bit tick, go, eom;
        int gap;
        if (reset) begin
            chk_on = 1'b1;
            acc    = 0;
            for (int k = 0; k < 2; k++) begin
                act[k] = 1'b0; in_gap[k] = 1'b0;
                mdone[k] = 1'b0; idx[k] = 0;
            end
        end else begin
            tick = (acc + INC) >= (1 << W);
            acc  = (acc + INC) % (1 << W);
            go   = enable && (msg_len != 0);
            for (int k = 0; k < 2; k++) begin
                gap      = (k == 0) ? G0 : G1;
                eom      = 1'b0;
                mdone[k] = 1'b0;
                if (!act[k]) begin
                    if (go) start_msg(k);
                end else if (tick) begin
                    pos[k]++;
                    if (pos[k] == seglen[k]) begin
                        if (in_gap[k]) eom = 1'b1;
                        else if (idx[k] + 1 < mlen[k]) begin
                            idx[k]++;
                            load_char(k);
                        end else if (gap > 0) begin
                            in_gap[k] = 1'b1;
                            pos[k]    = 0;
                            seglen[k] = gap;
                        end else eom = 1'b1;
                    end
                end
                if (eom) begin
                    mdone[k] = 1'b1;
                    if (go) start_msg(k);
                    else begin
                        act[k] = 1'b0; idx[k] = 0; in_gap[k] = 1'b0;
                    end
                end
            end
        end
        if (wr_en) mem_m[wr_addr] = wr_data;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++)
                check($sformatf("model%0d {tx,busy,done,idx}", k), pack(k),
                      {11'b0, exp_tx(k), act[k], mdone[k], AW'(idx[k])});
        end
    end

    task automatic adv(int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic go_to(int c);
        while (cyc < c) adv(1);
    endtask

    task automatic wr(int a, logic [DB-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sync(int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done[k] !== 1'b1 && n < 400);
        check($sformatf("sync%0d msg_done seen", k), 16'(done[k] === 1'b1),
              16'd1);
        cyc = 0;
    endtask

    task automatic run_vecs(int g);
        foreach (tbl[i]) begin
            if (tbl[i].grp == g) begin
                go_to(tbl[i].cyc);
                check($sformatf("vec g%0d c%0d", g, tbl[i].cyc),
                      pack(tbl[i].inst),
                      {11'b0, tbl[i].tx, tbl[i].busy, tbl[i].done, tbl[i].idx});
            end
        end
    endtask

    initial begin
        int l034 [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        int bad, nd, nb;

        for (int b = 0; b < 10; b++)
            tbl.push_back(mk(1, 0, 2 + P * b, 1'(l034[b]), 1, 0, 0));
        tbl.push_back(mk(1, 0, 40, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 41, 0, 1, 0, 0));
        for (int b = 0; b < 10; b++)
            tbl.push_back(mk(2, 1, 2 + P * b, fbit(8'h41, b), 1, 0, 0));
        for (int b = 0; b < 10; b++)
            tbl.push_back(mk(2, 1, 42 + P * b, fbit(8'h42, b), 1, 0, 1));
        for (int c = 82; c <= 90; c += P)
            tbl.push_back(mk(2, 1, c, 1, 1, 0, 1));
        tbl.push_back(mk(2, 1, 92, 0, 1, 1, 0));
        tbl.push_back(mk(2, 1, 93, 0, 1, 0, 0));

        reset = 1'b1;
        @(negedge clk);
        wr(0, 8'h14); wr(1, 8'h42); wr(2, 8'h0F); wr(3, 8'hA5);
        check("reset u0", pack(0), 16'h0010);
        check("reset u1", pack(1), 16'h0010);
        reset = 1'b0;

        enable = 1'b1; msg_len = '0; bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 2'b11 || busy !== 2'b00 || done !== 2'b00) bad++;
        end
        check("len0 stays idle", 16'(bad), 16'd0);

        msg_len = 1;
        sync(0);
        run_vecs(1);

        wr(0, 8'h41);
        msg_len = 2;
        sync(1);
        run_vecs(2);

        wr(0, 8'h14);
        msg_len = 1;
        sync(0);
        go_to(8);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55;
        adv(1);
        wr_en = 1'b0;
        go_to(30);
        check("write mid-frame keeps old bit6", 16'(tx[0]), 16'd0);
        go_to(46);
        check("next msg new bit0", 16'(tx[0]), 16'd1);
        go_to(70);
        check("next msg new bit6", 16'(tx[0]), 16'd1);

        sync(0);
        go_to(17);
        reset = 1'b1;
        adv(1);
        check("reset abort u0", pack(0), 16'h0010);
        check("reset abort u1", pack(1), 16'h0010);
        reset = 1'b0;
        adv(1);
        check("restart from char0", pack(0), 16'h0008);

        enable = 1'b0; bad = 0;
        while (busy[1] && bad < 600) begin
            adv(1);
            bad++;
        end
        check("u1 idle before drop test", 16'(busy[1]), 16'd0);
        msg_len = 2; enable = 1'b1; nd = 0; nb = 0;
        for (int i = 0; i < 210; i++) begin
            adv(1);
            if (i == 10) enable = 1'b0;
            nd += int'(done[1]);
            nb += int'(busy[1]);
        end
        check("drop: one msg_done", 16'(nd), 16'd1);
        check("drop: full msg busy len", 16'(nb >= 89 && nb <= 92), 16'd1);
        check("drop: back to idle", 16'(busy[1]), 16'd0);

        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = AW'($urandom_range(DEP - 1));
            wr_data = DB'($urandom);
            if ($urandom_range(40) == 0) enable = ~enable;
            if ($urandom_range(60) == 0) msg_len = (AW+1)'($urandom_range(7));
            reset = ($urandom_range(500) == 0);
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
